// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for uart_tx_arbiter.
// The master modport is the arbiter; the slave modport is the surrounding logic.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]   o_ack;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_tx_start;
  logic [7:0]           o_tx_data;
  logic                 i_tx_busy;

  modport master (
    input  i_req, i_data, i_tx_busy,
    output o_ack, o_grant, o_tx_start, o_tx_data
  );

  modport slave (
    output i_req, i_data, i_tx_busy,
    input  o_ack, o_grant, o_tx_start, o_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter among NUM_REQ requesters,
// with a bounded wait for the transmitter to acknowledge each start.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  uart_tx_arbiter_if.master bus,
  output logic              o_active,
  output logic              o_err,
  output logic [7:0]        o_tx_count
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_granted;
  logic [TO_W-1:0]    to_cnt;

  int unsigned        cand;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] win_onehot;
  logic [7:0]         win_data;

  // Candidate index wraps with one subtraction: last_granted+1+i never reaches 2*NUM_REQ.
  always_comb begin
    cand   = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(last_granted) + 32'd1 + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.i_req[IDX_W'(cand)]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
    win_data           = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == IDX_W'(k)) win_data = bus.i_data[8*k +: 8];
    end
  end

  assign o_active = (state != IDLE);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state          <= IDLE;
      last_granted   <= LAST_RST;
      to_cnt         <= '0;
      bus.o_ack      <= '0;
      bus.o_grant    <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data  <= '0;
      o_err          <= 1'b0;
      o_tx_count     <= '0;
    end else begin
      bus.o_ack      <= '0;
      bus.o_tx_start <= 1'b0;
      o_err          <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !bus.i_tx_busy) begin
            state          <= START;
            last_granted   <= winner;
            bus.o_grant    <= win_onehot;
            bus.o_tx_data  <= win_data;
            // Pulses are launched here so they are high exactly while in START.
            bus.o_tx_start <= 1'b1;
            bus.o_ack      <= win_onehot;
          end
        end
        START: begin
          state  <= WAIT_BUSY;
          to_cnt <= '0;
        end
        WAIT_BUSY: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus.i_tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            o_err       <= 1'b1;
            bus.o_grant <= '0;
            to_cnt      <= '0;
          end
        end
        WAIT_DONE: begin
          if (!bus.i_tx_busy) begin
            state       <= IDLE;
            o_tx_count  <= o_tx_count + 1'b1;
            bus.o_grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;
  logic       clk;
  logic       rst;
  logic       active;
  logic       err;
  logic [7:0] tx_count;

  int n_checks = 0;
  int n_pass   = 0;
  int m_last   = 3;
  int m_count  = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) ifc ();

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(8)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .bus        (ifc),
    .o_active   (active),
    .o_err      (err),
    .o_tx_count (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference: first requester after the last winner, cyclically.
  function automatic int pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (last + i) % 4;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    ifc.i_req = '0;
    ifc.i_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = 3;
    m_count = 0;
  endtask

  // Drives one transfer from IDLE and reports what the DUT did; no checking here.
  task automatic run_transfer(input logic [3:0] req, input logic [31:0] data,
                              input int delay, input int hold, input bit drop,
                              output logic [3:0] g, output logic [7:0] d,
                              output logic [3:0] a, output int starts,
                              output int acks, output bit stable, output bit tmo);
    int n;
    tmo = 1'b0; stable = 1'b1; starts = 0; acks = 0; g = '0; d = '0; a = '0;
    ifc.i_data = data;
    ifc.i_req  = req;
    n = 0;
    while (ifc.o_tx_start !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (ifc.o_tx_start !== 1'b1) begin
      tmo = 1'b1;
      ifc.i_req = '0;
      return;
    end
    starts = 1;
    g = ifc.o_grant; d = ifc.o_tx_data; a = ifc.o_ack; acks = $countones(ifc.o_ack);
    if (drop) ifc.i_req = '0;
    ifc.i_data = $urandom();
    for (int i = 0; i < delay + hold; i++) begin
      if (i == delay) ifc.i_tx_busy = 1'b1;
      @(posedge clk); #1;
      if (ifc.o_tx_start === 1'b1) starts++;
      acks += $countones(ifc.o_ack);
      if (ifc.o_grant !== g || ifc.o_tx_data !== d) stable = 1'b0;
    end
    ifc.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    if (ifc.o_tx_start === 1'b1) starts++;
    acks += $countones(ifc.o_ack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.i_req = 4'($urandom());
    ifc.i_data = $urandom();
    ifc.i_tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ifc.o_grant !== 4'b0) $display("FAIL rst_grant: got %b expected 0000", ifc.o_grant); else n_pass++;
    n_checks++; if (ifc.o_ack !== 4'b0) $display("FAIL rst_ack: got %b expected 0000", ifc.o_ack); else n_pass++;
    n_checks++; if (ifc.o_tx_start !== 1'b0) $display("FAIL rst_start: got %b expected 0", ifc.o_tx_start); else n_pass++;
    n_checks++; if (ifc.o_tx_data !== 8'h00) $display("FAIL rst_data: got %h expected 00", ifc.o_tx_data); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL rst_active: got %b expected 0", active); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (tx_count !== 8'h00) $display("FAIL rst_count: got %h expected 00", tx_count); else n_pass++;
    rst = 1'b0;
    ifc.i_req = '0;
    m_last = 3;
    m_count = 0;
  endtask

  task automatic test_single();
    logic [3:0] g, a; logic [7:0] d; int starts, acks; bit stable, tmo;
    run_transfer(4'b0001, {24'hA5C3E7, 8'h41}, 1, 10, 1'b1, g, d, a, starts, acks, stable, tmo);
    m_last = 0; m_count = (m_count + 1) % 256;
    n_checks++; if (tmo) $display("FAIL single_tmo: got no start expected start"); else n_pass++;
    n_checks++; if (starts != 1) $display("FAIL single_starts: got %0d expected 1", starts); else n_pass++;
    n_checks++; if (acks != 1 || a !== 4'b0001) $display("FAIL single_ack: got %b x%0d expected 0001 x1", a, acks); else n_pass++;
    n_checks++; if (g !== 4'b0001) $display("FAIL single_grant: got %b expected 0001", g); else n_pass++;
    n_checks++; if (d !== 8'h41) $display("FAIL single_data: got %h expected 41", d); else n_pass++;
    n_checks++; if (!stable) $display("FAIL single_stable: got unstable grant/data expected stable"); else n_pass++;
    n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL single_count: got %0d expected %0d", tx_count, m_count); else n_pass++;
    n_checks++; if (active !== 1'b0 || ifc.o_grant !== 4'b0) $display("FAIL single_idle: got active=%b grant=%b expected 0/0000", active, ifc.o_grant); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [3:0] g, a; logic [7:0] d; int starts, acks, exp; bit stable, tmo;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      run_transfer(4'b1111, 32'h13121110, 1 + t % 3, 2, 1'b0, g, d, a, starts, acks, stable, tmo);
      exp = pick(4'b1111, m_last);
      m_last = exp; m_count = (m_count + 1) % 256;
      n_checks++; if (tmo || g !== (4'b0001 << exp) || a !== (4'b0001 << exp))
        $display("FAIL fair_grant[%0d]: got grant=%b ack=%b expected %b", t, g, a, 4'b0001 << exp); else n_pass++;
      n_checks++; if (d !== 8'(8'h10 + exp)) $display("FAIL fair_data[%0d]: got %h expected %h", t, d, 8'(8'h10 + exp)); else n_pass++;
      n_checks++; if (starts != 1 || acks != 1 || !stable)
        $display("FAIL fair_pulses[%0d]: got starts=%0d acks=%0d stable=%b expected 1/1/1", t, starts, acks, stable); else n_pass++;
    end
    ifc.i_req = '0;
    n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL fair_count: got %0d expected %0d", tx_count, m_count); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [3:0] g, a; logic [7:0] d; int starts, acks, n, exp; bit stable, tmo, early;
    ifc.i_req = 4'b0010;
    ifc.i_data = $urandom();
    ifc.i_tx_busy = 1'b0;
    n = 0;
    while (ifc.o_tx_start !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (ifc.o_tx_start !== 1'b1 || ifc.o_grant !== 4'b0010)
      $display("FAIL tmo_grant: got start=%b grant=%b expected 1/0010", ifc.o_tx_start, ifc.o_grant); else n_pass++;
    m_last = 1;
    ifc.i_req = '0;
    early = 1'b0;
    for (int k = 1; k < 9; k++) begin
      @(posedge clk); #1;
      if (err !== 1'b0) early = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (early) $display("FAIL tmo_early: got err before timeout expected none"); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL tmo_err: got %b expected 1", err); else n_pass++;
    n_checks++; if (active !== 1'b0 || ifc.o_grant !== 4'b0) $display("FAIL tmo_idle: got active=%b grant=%b expected 0/0000", active, ifc.o_grant); else n_pass++;
    n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL tmo_count: got %0d expected %0d", tx_count, m_count); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b0 || ifc.o_tx_start !== 1'b0) $display("FAIL tmo_pulse: got err=%b start=%b expected 0/0", err, ifc.o_tx_start); else n_pass++;
    run_transfer(4'b0101, $urandom(), 2, 3, 1'b1, g, d, a, starts, acks, stable, tmo);
    exp = pick(4'b0101, m_last);
    m_last = exp; m_count = (m_count + 1) % 256;
    n_checks++; if (tmo || g !== (4'b0001 << exp)) $display("FAIL tmo_next: got %b expected %b", g, 4'b0001 << exp); else n_pass++;
  endtask

  task automatic test_busy_idle();
    bit spurious; int exp;
    ifc.i_tx_busy = 1'b1;
    ifc.i_req = 4'b0100;
    ifc.i_data = 32'h00C40000 | ($urandom() & 32'hFF00FFFF);
    spurious = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ifc.o_tx_start !== 1'b0 || active !== 1'b0) spurious = 1'b1;
    end
    n_checks++; if (spurious) $display("FAIL busyidle_hold: got start while busy expected none"); else n_pass++;
    ifc.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    exp = pick(4'b0100, m_last);
    m_last = exp;
    n_checks++; if (ifc.o_tx_start !== 1'b1 || ifc.o_grant !== (4'b0001 << exp) || ifc.o_ack !== (4'b0001 << exp))
      $display("FAIL busyidle_grant: got start=%b grant=%b ack=%b expected 1/%b", ifc.o_tx_start, ifc.o_grant, ifc.o_ack, 4'b0001 << exp); else n_pass++;
    n_checks++; if (ifc.o_tx_data !== 8'hC4) $display("FAIL busyidle_data: got %h expected c4", ifc.o_tx_data); else n_pass++;
    ifc.i_req = '0;
    @(posedge clk); #1;
    ifc.i_tx_busy = 1'b1;
    @(posedge clk); #1;
    ifc.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    m_count = (m_count + 1) % 256;
    n_checks++; if (tx_count !== 8'(m_count) || active !== 1'b0) $display("FAIL busyidle_done: got count=%0d active=%b expected %0d/0", tx_count, active, m_count); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] g, a, req; logic [7:0] d; logic [31:0] data; int starts, acks, exp; bit stable, tmo;
    for (int t = 0; t < 40; t++) begin
      req = 4'($urandom_range(1, 15));
      data = $urandom();
      run_transfer(req, data, $urandom_range(1, 4), $urandom_range(1, 6), 1'b1, g, d, a, starts, acks, stable, tmo);
      exp = pick(req, m_last);
      m_last = exp; m_count = (m_count + 1) % 256;
      n_checks++; if (tmo || g !== (4'b0001 << exp) || a !== g)
        $display("FAIL rand_grant[%0d]: req=%b got grant=%b ack=%b expected %b", t, req, g, a, 4'b0001 << exp); else n_pass++;
      n_checks++; if (d !== data[8*exp +: 8]) $display("FAIL rand_data[%0d]: got %h expected %h", t, d, data[8*exp +: 8]); else n_pass++;
      n_checks++; if (starts != 1 || acks != 1 || !stable)
        $display("FAIL rand_pulses[%0d]: got starts=%0d acks=%0d stable=%b expected 1/1/1", t, starts, acks, stable); else n_pass++;
      n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL rand_count[%0d]: got %0d expected %0d", t, tx_count, m_count); else n_pass++;
    end
  endtask

  task automatic test_wrap_reset();
    logic [3:0] g, a; logic [7:0] d; int starts, acks, n; bit stable, tmo, bad, spurious;
    apply_reset();
    bad = 1'b0;
    for (int t = 0; t < 256; t++) begin
      run_transfer(4'b0001, $urandom(), 1, 1, 1'b1, g, d, a, starts, acks, stable, tmo);
      m_count = (m_count + 1) % 256;
      if (tmo || starts != 1) bad = 1'b1;
      if (t == 254) begin
        n_checks++; if (tx_count !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", tx_count); else n_pass++;
      end
    end
    m_last = 0;
    n_checks++; if (bad) $display("FAIL wrap_seq: got missing/extra starts expected one per transfer"); else n_pass++;
    n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL wrap_zero: got %0d expected %0d", tx_count, m_count); else n_pass++;
    // Reset while the transmitter is mid-byte.
    ifc.i_req = 4'b0010;
    ifc.i_data = $urandom();
    n = 0;
    while (ifc.o_tx_start !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ifc.i_tx_busy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (active !== 1'b1 || ifc.o_grant !== 4'b0010) $display("FAIL rstmid_pre: got active=%b grant=%b expected 1/0010", active, ifc.o_grant); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 3;
    m_count = 0;
    n_checks++; if (ifc.o_grant !== 4'b0 || ifc.o_ack !== 4'b0 || ifc.o_tx_start !== 1'b0 || ifc.o_tx_data !== 8'h00)
      $display("FAIL rstmid_bus: got grant=%b ack=%b start=%b data=%h expected 0000/0000/0/00", ifc.o_grant, ifc.o_ack, ifc.o_tx_start, ifc.o_tx_data); else n_pass++;
    n_checks++; if (active !== 1'b0 || err !== 1'b0 || tx_count !== 8'h00)
      $display("FAIL rstmid_status: got active=%b err=%b count=%0d expected 0/0/0", active, err, tx_count); else n_pass++;
    ifc.i_req = 4'b0110;
    ifc.i_data = 32'h00_00_B2_00 | ($urandom() & 32'hFFFF00FF);
    spurious = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ifc.o_tx_start !== 1'b0) spurious = 1'b1;
    end
    n_checks++; if (spurious) $display("FAIL rstmid_nostart: got start while busy expected none"); else n_pass++;
    ifc.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ifc.o_tx_start !== 1'b1 || ifc.o_grant !== (4'b0001 << pick(4'b0110, m_last)) || ifc.o_tx_data !== 8'hB2)
      $display("FAIL rstmid_regrant: got start=%b grant=%b data=%h expected 1/%b/b2", ifc.o_tx_start, ifc.o_grant, ifc.o_tx_data, 4'b0001 << pick(4'b0110, m_last)); else n_pass++;
    ifc.i_req = '0;
    @(posedge clk); #1;
    ifc.i_tx_busy = 1'b1;
    @(posedge clk); #1;
    ifc.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    m_count = 1;
    n_checks++; if (tx_count !== 8'(m_count)) $display("FAIL rstmid_count: got %0d expected %0d", tx_count, m_count); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    ifc.i_req = '0;
    ifc.i_data = '0;
    ifc.i_tx_busy = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_busy_idle();
    test_random();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters sharing the transmitter.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 8, max cycles waited for transmitter busy to rise after start.
REQ-003 SHALL have port i_Clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester send request, level.
REQ-006 SHALL have port i_data  input  8*NUM_REQ  per-requester byte; requester k at bits [8k+7:8k].
REQ-007 SHALL have port o_ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte latched.
REQ-008 SHALL have port o_grant  output  NUM_REQ  one-hot owner of current transfer; 0 when idle.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle start pulse to transmitter.
REQ-010 SHALL have port o_tx_data  output  8  byte to transmitter.
REQ-011 SHALL have port i_tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port o_active  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse on busy timeout.
REQ-014 SHALL have port o_tx_count  output  8  completed-byte counter, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE in a registered state machine.
REQ-016 IDLE: SHALL grant only when |i_req and i_tx_busy==0; otherwise SHALL stay IDLE with no outputs asserted.
REQ-017 Grant SHALL be round-robin: search starts at last_granted+1 mod NUM_REQ; last_granted resets to NUM_REQ-1 (requester 0 first).
REQ-018 On grant edge: o_tx_data <= winner's byte, o_grant <= onehot(winner), last_granted <= winner, state <= START.
REQ-019 START: o_tx_start=1 and o_ack[winner]=1 for exactly this one cycle; next state WAIT_BUSY unconditionally.
REQ-020 WAIT_BUSY: on i_tx_busy==1 SHALL go WAIT_DONE; timeout counter increments each cycle here, cleared on entry.
REQ-021 If BUSY_TIMEOUT cycles elapse in WAIT_BUSY without busy, SHALL go IDLE, pulse o_err one cycle, clear o_grant, not increment o_tx_count.
REQ-022 WAIT_DONE: on i_tx_busy==0 SHALL go IDLE, increment o_tx_count (mod 256), clear o_grant.
REQ-023 o_tx_data and o_grant SHALL stay stable from START through WAIT_DONE; i_data changes after ack SHALL be ignored.
REQ-024 i_req SHALL be sampled only in IDLE; requests arriving mid-transfer wait; a requester holding i_req after ack is eligible again but only after all other active requesters (fairness).
REQ-025 Minimum spacing between o_tx_start pulses SHALL be 1 IDLE cycle after busy falls (IDLE->START->WAIT_BUSY->WAIT_DONE->IDLE).
REQ-026 Simultaneous requests SHALL be resolved by REQ-017 alone; exactly one o_ack bit per transfer.
REQ-027 Latency: i_req seen in IDLE at edge N -> o_tx_start/o_ack high during cycle after edge N.

Reset
REQ-028 While i_Rst high at a clock edge: state IDLE, o_ack 0, o_grant 0, o_tx_start 0, o_tx_data 0x00, o_active 0, o_err 0, o_tx_count 0, timeout counter 0, last_granted NUM_REQ-1.
REQ-029 Reset mid-transfer SHALL abort sequencing only; an in-flight transmitter byte is not cancelled, and REQ-016 prevents a new grant until i_tx_busy==0.

Verification
REQ-030 Single request: i_req=0001, i_data[7:0]=0x41, busy rises 1 cycle after start, held 10 cycles -> one start pulse, o_tx_data=0x41, o_ack=0001 once, o_tx_count=1.
REQ-031 All-request fairness: i_req=1111 held, bytes 0x10/0x11/0x12/0x13 -> grant order 0,1,2,3,0 and data sequence matches.
REQ-032 Timeout: i_req=0010, i_tx_busy held 0 -> o_err pulse after 8 WAIT_BUSY cycles, state IDLE, o_tx_count unchanged, next grant goes to requester 2 search-first.
REQ-033 Busy at idle: i_tx_busy=1 with i_req=0100 -> no start until busy=0, then grant 0100 next edge.
REQ-034 Wrap and reset: 256 completed transfers -> o_tx_count 0; assert i_Rst in WAIT_DONE -> all outputs at reset values next edge, no start while busy remains high.
